fifo_576bit_wr_packer: RTL and testbench

Write-side front end for the 576-bit dual-clock FWFT FIFO. It packs a narrow AXI-stream in the wr_clk domain into 512-bit data words and adds 64 bits of sideband: last flag, valid byte count and packet sequence number. It drives din/wr_en into the FIFO, respects full, and throttles on the write-side occupancy count. The read-side consumer unpacks the sideband.

---
 rtl/fifo_576bit_wr_packer.sv | 141 ++++++++++++++
 tb/tb_fifo_576bit_wr_packer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_576bit_wr_packer.sv
// Packs a narrow AXI-stream into 512-bit FIFO words with last/byte-count/sequence sideband,
// driving a dual-clock FWFT FIFO on the write side with full and occupancy back-pressure.
module fifo_576bit_wr_packer #(
    parameter int IDSIZE       = 64,
    parameter int DSIZE        = 576,
    parameter int AFULL_THRESH = 500
) (
    input  logic                  wr_clk,
    input  logic                  RST,
    input  logic [IDSIZE-1:0]     s_tdata,
    input  logic [IDSIZE/8-1:0]   s_tkeep,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [DSIZE-1:0]      fifo_din,
    output logic                  fifo_wr_en,
    input  logic                  fifo_full,
    input  logic [8:0]            fifo_wcount,
    output logic [15:0]           pkt_cnt,
    output logic                  drop_err
);

    localparam int RATIO = 512 / IDSIZE;
    localparam int KW    = IDSIZE / 8;
    localparam int IW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CW    = 7;

    typedef enum logic [1:0] {IDLE, FILL, STALL} state_t;

    state_t             state_p0;
    state_t             state_nxt;
    logic               run_p0;
    logic [511:0]       acc_p0;
    logic [IW-1:0]      idx_p0;
    logic [15:0]        seq_p0;
    logic [DSIZE-1:0]   stall_word_p0;
    logic [DSIZE-1:0]   dout_p1;
    logic               vld_p1;
    logic [15:0]        pkt_cnt_q;
    logic               drop_q;

    logic               accept;
    logic               complete;
    logic               out_busy;
    logic               wr_en;
    logic               stall_now;
    logic               load_p1;
    logic [511:0]       word_data;
    logic [CW-1:0]      byte_cnt;
    logic [575:0]       word_full;
    logic [DSIZE-1:0]   new_word;
    logic [DSIZE-1:0]   load_word;

    function automatic logic [CW-1:0] popcount(input logic [KW-1:0] k);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < KW; i++) n = n + CW'(k[i]);
        return n;
    endfunction

    // Valid keep patterns are a run of ones starting at byte 0 (including all-zero).
    function automatic logic contiguous(input logic [KW-1:0] k);
        return ((k & (k + KW'(1))) == '0);
    endfunction

    assign stall_now = (state_p0 == STALL);
    assign s_tready  = run_p0 && !stall_now && (32'(fifo_wcount) < AFULL_THRESH);
    assign accept    = s_tvalid && s_tready;
    assign complete  = accept && (s_tlast || (idx_p0 == IW'(RATIO - 1)));
    assign wr_en     = vld_p1 && !fifo_full;
    assign out_busy  = vld_p1 && fifo_full;

    // Lanes at and above idx are still zero in the accumulator, so OR-ing places the beat.
    assign word_data = acc_p0 | (512'(s_tdata) << (int'(idx_p0) * IDSIZE));
    assign byte_cnt  = s_tlast ? (CW'(idx_p0) * CW'(KW) + popcount(s_tkeep)) : CW'(RATIO * KW);
    assign word_full = {40'b0, seq_p0, byte_cnt, s_tlast, word_data};
    assign new_word  = word_full[DSIZE-1:0];

    assign load_p1   = (complete && !out_busy) || (stall_now && wr_en);
    assign load_word = stall_now ? stall_word_p0 : new_word;

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            STALL:   if (wr_en) state_nxt = IDLE;
            default: begin
                if (complete)    state_nxt = out_busy ? STALL : IDLE;
                else if (accept) state_nxt = FILL;
            end
        endcase
    end

    // Stage p0: lane accumulator, packet sequence and FSM.
    always_ff @(posedge wr_clk or posedge RST) begin
        if (RST) begin
            state_p0      <= IDLE;
            run_p0        <= 1'b0;
            acc_p0        <= '0;
            idx_p0        <= '0;
            seq_p0        <= '0;
            stall_word_p0 <= '0;
            drop_q        <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            run_p0   <= 1'b1;
            if (complete) begin
                acc_p0 <= '0;
                idx_p0 <= '0;
                if (out_busy) stall_word_p0 <= new_word;
                if (s_tlast)  seq_p0 <= seq_p0 + 16'd1;
            end else if (accept) begin
                acc_p0 <= word_data;
                idx_p0 <= idx_p0 + IW'(1);
            end
            if (accept && s_tlast && !contiguous(s_tkeep)) drop_q <= 1'b1;
        end
    end

    // Stage p1: output holding register feeding the FIFO.
    always_ff @(posedge wr_clk or posedge RST) begin
        if (RST) begin
            dout_p1   <= '0;
            vld_p1    <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            if (load_p1) begin
                dout_p1 <= load_word;
                vld_p1  <= 1'b1;
            end else if (wr_en) begin
                vld_p1  <= 1'b0;
            end
            if (wr_en && dout_p1[512]) pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end

    assign fifo_din   = dout_p1;
    assign fifo_wr_en = wr_en;
    assign pkt_cnt    = pkt_cnt_q;
    assign drop_err   = drop_q;

endmodule

// File: tb/tb_fifo_576bit_wr_packer.sv
// Scoreboard bench for fifo_576bit_wr_packer: a packet-level model predicts FIFO words,
// and a monitor compares every FIFO write, pkt_cnt and the almost-full ready gating.
module tb_fifo_576bit_wr_packer;

    localparam int THRESH = 500;

    logic         wr_clk = 1'b0;
    logic         RST = 1'b1;
    logic [63:0]  s_tdata = '0;
    logic [7:0]   s_tkeep = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tlast = 1'b0;
    logic         s_tready;
    logic [575:0] fifo_din;
    logic         fifo_wr_en;
    logic         fifo_full = 1'b0;
    logic [8:0]   fifo_wcount = '0;
    logic [15:0]  pkt_cnt;
    logic         drop_err;

    int           checks = 0;
    int           errors = 0;
    logic [575:0] exp_q[$];
    logic [63:0]  beats[$];
    logic [15:0]  seq_m = '0;
    logic [15:0]  exp_pkt = '0;
    logic         exp_drop = 1'b0;
    int           stall_cycles = 0;
    bit           rand_mode = 1'b0;

    fifo_576bit_wr_packer dut (
        .wr_clk      (wr_clk),
        .RST         (RST),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .fifo_din    (fifo_din),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_full   (fifo_full),
        .fifo_wcount (fifo_wcount),
        .pkt_cnt     (pkt_cnt),
        .drop_err    (drop_err)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string name, input logic [575:0] act, input logic [575:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: collect beats of a packet; emit a word per 8 beats or at tlast.
    task automatic model_accept(input logic [63:0] d, input logic [7:0] k, input logic l);
        logic [575:0] w;
        int           cnt;
        beats.push_back(d);
        if (l || beats.size() == 8) begin
            w = '0;
            foreach (beats[i]) w[i*64 +: 64] = beats[i];
            cnt = l ? ((beats.size() - 1) * 8 + $countones(k)) : 64;
            w[512]      = l;
            w[519:513]  = 7'(cnt);
            w[535:520]  = seq_m;
            exp_q.push_back(w);
            beats.delete();
            if (l) begin
                seq_m = seq_m + 16'd1;
                if (k != 8'((9'(1) << $countones(k)) - 9'(1))) exp_drop = 1'b1;
            end
        end
    endtask

    always @(negedge wr_clk)
        if (!RST && s_tvalid && s_tready) model_accept(s_tdata, s_tkeep, s_tlast);

    always @(negedge wr_clk) begin
        logic [575:0] w;
        if (!RST) begin
            chk("pkt_cnt", 576'(pkt_cnt), 576'(exp_pkt));
            if (fifo_wcount >= 9'(THRESH)) chk("tready_afull", 576'(s_tready), 576'(0));
            if (fifo_wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got din %h with no word expected", fifo_din);
                end else begin
                    w = exp_q.pop_front();
                    chk("fifo_din", fifo_din, w);
                    if (w[512]) exp_pkt = exp_pkt + 16'd1;
                end
            end
        end
    end

    always @(posedge wr_clk) begin
        #1;
        if (rand_mode) begin
            fifo_full   = ($urandom_range(0, 3) == 0);
            fifo_wcount = ($urandom_range(0, 7) == 0) ? 9'(THRESH + $urandom_range(0, 11))
                                                     : 9'($urandom_range(0, THRESH - 1));
        end
    end

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n;
        bit ok;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 300) begin
            @(negedge wr_clk);
            n++;
            if (s_tready) ok = 1'b1;
            else stall_cycles++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got no s_tready in %0d cycles, required acceptance", n);
        end
        @(posedge wr_clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = {$urandom, $urandom};
        repeat (n) @(posedge wr_clk);
        #1;
    endtask

    task automatic send_pkt(input int len, input logic [7:0] lastkeep, input bit gaps);
        logic [7:0] k;
        for (int b = 0; b < len; b++) begin
            k = (b == len - 1) ? lastkeep : 8'($urandom);
            drive_beat({$urandom, $urandom}, k, b == len - 1);
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge wr_clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words pending, required 0", exp_q.size());
        end
        @(posedge wr_clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_tready", 576'(s_tready), 576'(0));
        chk("rst_wr_en", 576'(fifo_wr_en), 576'(0));
        chk("rst_din", fifo_din, 576'(0));
        chk("rst_pkt_cnt", 576'(pkt_cnt), 576'(0));
        chk("rst_drop", 576'(drop_err), 576'(0));
        #20 RST = 1'b0;
        @(posedge wr_clk);
        #1;

        for (int i = 1; i <= 8; i++) drive_beat(64'(i), 8'hFF, i == 8);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk("t1_wr_latency", 576'(fifo_wr_en), 576'(1));
        chk("t1_count", 576'(fifo_din[519:513]), 576'(64));
        idle(2);

        send_pkt(3, 8'h0F, 1'b0);
        chk("t2_wr_latency", 576'(fifo_wr_en), 576'(1));
        chk("t2_count", 576'(fifo_din[519:513]), 576'(20));
        idle(2);

        stall_cycles = 0;
        send_pkt(20, 8'hFF, 1'b0);
        chk("t3_no_backpressure", 576'(stall_cycles), 576'(0));
        drain();

        fifo_full = 1'b1;
        send_pkt(16, 8'hFF, 1'b0);
        chk("t4_stall_tready", 576'(s_tready), 576'(0));
        chk("t4_held_wr_en", 576'(fifo_wr_en), 576'(0));
        @(posedge wr_clk);
        #1;
        chk("t4_stall_tready2", 576'(s_tready), 576'(0));
        fifo_full = 1'b0;
        @(negedge wr_clk);
        chk("t4_write1", 576'(fifo_wr_en), 576'(1));
        @(negedge wr_clk);
        chk("t4_write2", 576'(fifo_wr_en), 576'(1));
        drain();

        fifo_wcount = 9'd500;
        s_tdata  = 64'hA5A5_0000_1234_5678;
        s_tkeep  = 8'hFF;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        @(negedge wr_clk);
        chk("t5_thresh500", 576'(s_tready), 576'(0));
        @(posedge wr_clk);
        #1;
        fifo_wcount = 9'd499;
        @(negedge wr_clk);
        chk("t5_thresh499", 576'(s_tready), 576'(1));
        @(posedge wr_clk);
        #1;
        s_tvalid    = 1'b0;
        s_tlast     = 1'b0;
        fifo_wcount = '0;
        drain();

        drive_beat(64'hDEAD_BEEF_0000_0001, 8'h00, 1'b1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk("keep0_count", 576'(fifo_din[519:512]), 576'(8'h01));
        drain();

        chk("drop_before", 576'(drop_err), 576'(exp_drop));
        send_pkt(2, 8'b0000_0101, 1'b0);
        idle(2);
        chk("drop_after", 576'(drop_err), 576'(exp_drop));
        drain();

        rand_mode = 1'b1;
        for (int p = 0; p < 40; p++) begin
            send_pkt($urandom_range(1, 20), 8'((9'(1) << $urandom_range(0, 8)) - 9'(1)), 1'b1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        rand_mode = 1'b0;
        @(posedge wr_clk);
        #2;
        fifo_full   = 1'b0;
        fifo_wcount = '0;
        drain();
        chk("drop_sticky", 576'(drop_err), 576'(exp_drop));

        send_pkt(5, 8'hFF, 1'b0);
        for (int b = 0; b < 5; b++) drive_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        s_tvalid = 1'b0;
        @(posedge wr_clk);
        #3;
        RST = 1'b1;
        beats.delete();
        exp_q.delete();
        seq_m    = '0;
        exp_pkt  = '0;
        exp_drop = 1'b0;
        #1;
        chk("t6_tready", 576'(s_tready), 576'(0));
        chk("t6_wr_en", 576'(fifo_wr_en), 576'(0));
        chk("t6_din", fifo_din, 576'(0));
        chk("t6_pkt_cnt", 576'(pkt_cnt), 576'(0));
        chk("t6_drop", 576'(drop_err), 576'(0));
        #10 RST = 1'b0;
        @(posedge wr_clk);
        #1;
        send_pkt(8, 8'hFF, 1'b0);
        drain();
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
